// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdm_pkg
// Description : Shared constants and helpers for the multi-channel PDM modulator.
// Revision    : 1.0
// ============================================================================
package pdm_pkg;

    typedef enum logic [1:0] {
        PDM_ORD1 = 2'd1,
        PDM_ORD2 = 2'd2
    } pdm_order_e;

    // Headroom above the sample width for the error / integrator registers.
    localparam int c_err_extra = 2;
    localparam int c_int_extra = 4;
    localparam int c_sat_shift = 2;

    function automatic int fs_pos(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int fs_neg(input int width);
        return -(1 << (width - 1));
    endfunction

    function automatic int sat_lim(input int width);
        return 1 << (width + c_sat_shift);
    endfunction

    function automatic int sat(input int x, input int lim);
        if (x > lim) begin
            return lim;
        end
        if (x < -lim) begin
            return -lim;
        end
        return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pdm_channel
// Description : One noise-shaping PDM modulator (first or second order).
// Revision    : 1.0
// ============================================================================
module pdm_channel
    import pdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ORDER = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic                    i_tick,
    input  logic signed [WIDTH-1:0] i_level,
    output logic                    o_bit
);

    localparam int c_fs_pos = fs_pos(WIDTH);
    localparam int c_fs_neg = fs_neg(WIDTH);

    logic r_bit;
    int   w_fb;

    assign w_fb  = r_bit ? c_fs_pos : c_fs_neg;
    assign o_bit = r_bit;

    generate
        if (ORDER == int'(PDM_ORD1)) begin : g_ord1
            localparam int c_ew = WIDTH + c_err_extra;

            logic signed [c_ew-1:0] r_err;
            int                     w_err_next;

            assign w_err_next = int'(r_err) + int'(i_level) - w_fb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_err <= '0;
                    r_bit <= 1'b0;
                end else if (!i_enable) begin
                    r_bit <= 1'b0;
                end else if (i_tick) begin
                    r_err <= c_ew'(w_err_next);
                    r_bit <= (w_err_next > 0);
                end
            end
        end else if (ORDER == int'(PDM_ORD2)) begin : g_ord2
            localparam int c_iw  = WIDTH + c_int_extra;
            localparam int c_lim = sat_lim(WIDTH);

            logic signed [c_iw-1:0] r_i1;
            logic signed [c_iw-1:0] r_i2;
            int                     w_i1_next;
            int                     w_i2_next;

            // Sums are formed at int width so the clamp sees the true value.
            always_comb begin
                w_i1_next = sat(int'(r_i1) + int'(i_level) - w_fb, c_lim);
                w_i2_next = sat(int'(r_i2) + w_i1_next - w_fb, c_lim);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_i1  <= '0;
                    r_i2  <= '0;
                    r_bit <= 1'b0;
                end else if (!i_enable) begin
                    r_bit <= 1'b0;
                end else if (i_tick) begin
                    r_i1  <= c_iw'(w_i1_next);
                    r_i2  <= c_iw'(w_i2_next);
                    r_bit <= (w_i2_next > 0);
                end
            end
        end else begin : g_bad_order
            $error("pdm_channel: ORDER must be 1 or 2");
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pdm_modulator_mc.sv
`default_nettype none
// ============================================================================
// Module      : pdm_modulator_mc
// Description : Multi-channel PDM modulator with one-frame buffer and tick generator.
// Revision    : 1.0
// ============================================================================
module pdm_modulator_mc
    import pdm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int CLK_DIV  = 32,
    parameter int OSR      = 16,
    parameter int ORDER    = 1
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         enable_in,
    input  logic                         mute_in,
    input  logic [CHANNELS*WIDTH-1:0]    sample_in,
    input  logic                         sample_valid_in,
    output logic                         sample_ready_out,
    output logic                         tick_out,
    output logic                         frame_out,
    output logic                         underrun_out,
    output logic [CHANNELS-1:0]          pdm_out
);

    localparam int                  c_cw       = CHANNELS * WIDTH;
    localparam int                  c_div_w    = $clog2(CLK_DIV);
    localparam int                  c_osr_w    = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_osr_w-1:0]  c_osr_last = c_osr_w'(OSR - 1);

    logic [c_div_w-1:0] r_div_cnt;
    logic [c_osr_w-1:0] r_osr_cnt;
    logic               r_buf_full;
    logic [c_cw-1:0]    r_buf;
    logic [c_cw-1:0]    r_lvl;
    logic [c_cw-1:0]    w_lvl_eff;
    logic               w_tick;
    logic               w_boundary;
    logic               w_accept;

    assign w_tick     = enable_in && (r_div_cnt == c_div_last);
    assign w_boundary = w_tick && (r_osr_cnt == c_osr_last);
    assign w_accept   = sample_valid_in && !r_buf_full;

    assign sample_ready_out = !r_buf_full;
    assign tick_out         = w_tick;
    assign frame_out        = w_boundary;
    assign underrun_out     = w_boundary && !r_buf_full;

    // The level seen by the channels on a boundary tick is the new one.
    always_comb begin
        w_lvl_eff = r_lvl;
        if (w_boundary) begin
            w_lvl_eff = (r_buf_full && !mute_in) ? r_buf : '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_div_cnt <= '0;
            r_osr_cnt <= '0;
        end else if (!enable_in) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_osr_cnt <= w_boundary ? '0 : r_osr_cnt + 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_buf_full <= 1'b0;
            r_buf      <= '0;
            r_lvl      <= '0;
        end else begin
            if (w_accept) begin
                r_buf_full <= 1'b1;
                r_buf      <= sample_in;
            end else if (w_boundary) begin
                r_buf_full <= 1'b0;
            end
            if (w_boundary) begin
                r_lvl <= w_lvl_eff;
            end
        end
    end

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
            pdm_channel #(
                .WIDTH (WIDTH),
                .ORDER (ORDER)
            ) u_ch (
                .clk      (clk_in),
                .rst_n    (rst_n_in),
                .i_enable (enable_in),
                .i_tick   (w_tick),
                .i_level  (w_lvl_eff[k*WIDTH +: WIDTH]),
                .o_bit    (pdm_out[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire
